snake_body: RTL and testbench
=============================

Name: snake_body

Overview:
- Owns the snake: a ring buffer of segment coordinates, the head position, and the snake's length.
- On each game `step` it moves the head one pixel in the latched direction and checks for self-collision.
- It then streams erase-tail and draw-head pixels to the VGA plotter over a valid/ready handshake.
- It supplies `h_x`/`h_y` to the food block and consumes the food block's `grow` length target.

Parameters:
- MAX_LEN, 256: ring-buffer depth; maximum snake length (power of two).
- START_X, 80: head x after reset.
- START_Y, 60: head y after reset.
- X_MAX, 159: last valid column; x wraps between X_MAX and 0.
- Y_MAX, 119: last valid row; y wraps between Y_MAX and 0.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- step  in  1  one-cycle move request; honoured only in IDLE, otherwise dropped.
- dir  in  4  one-hot direction request: [0] up, [1] down, [2] left, [3] right.
- grow  in  11  target length from food.
- h_x  out  8  current head column.
- h_y  out  7  current head row.
- plot_valid  out  1  pixel beat pending.
- plot_ready  in  1  plotter accepts the beat.
- plot_x  out  8  beat column.
- plot_y  out  7  beat row.
- plot_colour  out  3  beat colour.
- busy  out  1  high in any state other than IDLE or DEAD.
- dead  out  1  self-collision occurred; sticky until reset.

Behaviour:
- Reset (async, takes effect immediately):
  - buffer[0] = (START_X, START_Y); head_ptr = 0; len = 1; cur_dir = right.
  - h_x = START_X, h_y = START_Y.
  - plot_valid = 0, plot_x = 0, plot_y = 0, plot_colour = 0, dead = 0, busy = 1.
  - State = INIT_DRAW.
  - Reset during any state, including mid-handshake, abandons that beat.
- Direction latch (every cycle, any state except DEAD):
  - cur_dir <= dir only if dir is exactly one-hot and is not the opposite of cur_dir.
  - All-zero, multi-hot and reversal requests are ignored.
- target = 1 if grow == 0; MAX_LEN if grow > MAX_LEN; otherwise grow.
- growing = (len < target).
- States:
  - INIT_DRAW: present beat (START_X, START_Y, 3'b010); on transfer go to IDLE.
  - IDLE: busy = 0. On step, compute nxt = head ± 1 per cur_dir with wrap (right from X_MAX → 0, left from 0 → X_MAX, down from Y_MAX → 0, up from 0 → Y_MAX), clear scan index, go to CHECK.
  - CHECK: compares one buffer entry per cycle against nxt.
    - Scan covers entries tail..head when growing, or tail+1..head when not growing (the tail will be vacated).
    - Scan length is len or len−1; a zero-length scan goes straight to COMMIT.
    - Any match → DEAD.
    - End of scan with no match → COMMIT.
  - COMMIT (1 cycle):
    - Write nxt at head_ptr+1 (mod MAX_LEN); head_ptr++.
    - h_x/h_y <= nxt.
    - If growing: len++ and go to DRAW_HEAD.
    - Else: capture old tail coordinate and go to ERASE_TAIL.
  - ERASE_TAIL: beat (old tail, 3'b000); on transfer → DRAW_HEAD. The erase precedes the draw so a head entering the vacated tail cell stays visible.
  - DRAW_HEAD: beat (h_x, h_y, 3'b010); on transfer → IDLE.
  - DEAD: dead = 1, busy = 0, plot_valid = 0. step and dir are ignored; leaves only on reset.
- Tail index = head_ptr − len + 1 (mod MAX_LEN), ADDR_W = log2(MAX_LEN) arithmetic.
- Handshake:
  - A beat transfers on a rising edge with plot_valid && plot_ready.
  - plot_x, plot_y and plot_colour stay stable while valid && !ready.
  - plot_valid drops the cycle after the final transfer.
  - No combinational path from plot_ready to plot_valid.
- Latency, step to h_x change: 1 (IDLE → CHECK) + scan cycles + 1 (COMMIT).

Test Plan:
- Reset, plot_ready = 1: exactly one beat (80, 60, 010); busy falls; h_x = 80, h_y = 60, dead = 0.
- grow = 6, dir = right, 5 steps:
  - h_x goes 81..85 with only draw beats and no erase.
  - 6th step gives erase (80, 60, 000) then draw (86, 60, 010).
- Head at x = 159 moving right, step: h_x = 0, draw (0, 60). Repeat at y = 0 moving up: h_y = 119.
- Moving right, dir = left (4'b0100) then step: h_x increments; dir = 4'b0011 ignored likewise.
- Self-collision and tail boundary:
  - From reset, grow = 6, steps R, D, L, U: the 4th step hits (80, 60); dead = 1, no beats, later steps ignored.
  - Same sequence with grow = 4: no death; erase (80, 60) then draw (80, 60).
- Backpressure and reset mid-operation:
  - Hold plot_ready = 0 for 10 cycles during ERASE_TAIL: beat fields constant, busy = 1, extra step pulses dropped.
  - Assert rst mid-beat: outputs return to reset values at once; INIT_DRAW beat follows.

Source files
------------

// File: rtl/snake_body.sv
// Snake body: ring buffer of segments, head stepping with wrap, self-collision scan, pixel beats to plotter.
// Latency: step -> h_x/h_y update = 1 (IDLE->CHECK) + scan cycles (min 1) + 1 (COMMIT); beats follow COMMIT.
// Backpressure: plot beats are registered and held stable while plot_valid && !plot_ready; steps outside IDLE are dropped.
module snake_body #(
  parameter int MAX_LEN = 256,
  parameter int START_X = 80,
  parameter int START_Y = 60,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [3:0]  dir,
  input  logic [10:0] grow,
  output logic [7:0]  h_x,
  output logic [6:0]  h_y,
  output logic        plot_valid,
  input  logic        plot_ready,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  plot_colour,
  output logic        busy,
  output logic        dead
);

  localparam int ADDR_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    INIT_DRAW, IDLE, CHECK, COMMIT, ERASE_TAIL, DRAW_HEAD, DEAD
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cur_dir;
  logic [ADDR_W-1:0] head_ptr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   scan_idx;
  logic [ADDR_W:0]   scan_len;
  logic [7:0]        nxt_x;
  logic [6:0]        nxt_y;
  logic              grow_l;
  logic [14:0]       ring [MAX_LEN];

  logic [10:0]       target;
  logic              growing;
  logic [ADDR_W-1:0] tail_idx, scan_addr, commit_addr;
  logic [14:0]       scan_ent, tail_ent;
  logic              hit, scan_last, xfer;
  logic [7:0]        step_x;
  logic [6:0]        step_y;
  logic [3:0]        opp_dir;
  logic              dir_ok;
  logic              beat_vld;
  logic [7:0]        beat_x;
  logic [6:0]        beat_y;
  logic [2:0]        beat_col;

  // Length target, ring addressing and collision compare.
  always_comb begin
    if (grow == 11'd0)
      target = 11'd1;
    else if (grow > 11'(MAX_LEN))
      target = 11'(MAX_LEN);
    else
      target = grow;
    growing     = 11'(len) < target;
    tail_idx    = head_ptr - len[ADDR_W-1:0] + 1'b1;
    commit_addr = head_ptr + 1'b1;
    // When not growing the tail cell is about to be vacated, so skip it.
    scan_addr   = tail_idx + {{(ADDR_W-1){1'b0}}, ~grow_l} + scan_idx[ADDR_W-1:0];
    scan_len    = grow_l ? len : len - 1'b1;
    scan_ent    = ring[scan_addr];
    tail_ent    = ring[tail_idx];
    hit         = scan_ent == {nxt_x, nxt_y};
    scan_last   = (scan_idx + 1'b1) == scan_len;
    xfer        = plot_valid && plot_ready;
    opp_dir     = {cur_dir[2], cur_dir[3], cur_dir[0], cur_dir[1]};
    dir_ok      = (dir == 4'b0001 || dir == 4'b0010 || dir == 4'b0100 || dir == 4'b1000)
                  && (dir != opp_dir);
  end

  // Candidate head position one pixel along cur_dir, wrapping at the screen edges.
  always_comb begin
    step_x = h_x;
    step_y = h_y;
    if (cur_dir[3])
      step_x = (h_x == 8'(X_MAX)) ? 8'd0 : h_x + 8'd1;
    else if (cur_dir[2])
      step_x = (h_x == 8'd0) ? 8'(X_MAX) : h_x - 8'd1;
    else if (cur_dir[1])
      step_y = (h_y == 7'(Y_MAX)) ? 7'd0 : h_y + 7'd1;
    else if (cur_dir[0])
      step_y = (h_y == 7'd0) ? 7'(Y_MAX) : h_y - 7'd1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= INIT_DRAW;
    else
      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT_DRAW:  if (xfer) state_nxt = IDLE;
      IDLE:       if (step) state_nxt = CHECK;
      CHECK: begin
        if (scan_len == '0)   state_nxt = COMMIT;
        else if (hit)         state_nxt = DEAD;
        else if (scan_last)   state_nxt = COMMIT;
      end
      COMMIT:     state_nxt = grow_l ? DRAW_HEAD : ERASE_TAIL;
      ERASE_TAIL: if (xfer) state_nxt = DRAW_HEAD;
      DRAW_HEAD:  if (xfer) state_nxt = IDLE;
      DEAD:       state_nxt = DEAD;
      default:    state_nxt = INIT_DRAW;
    endcase
  end

  // Status outputs and the beat to present for the upcoming state.
  always_comb begin
    busy     = (state != IDLE) && (state != DEAD);
    dead     = state == DEAD;
    beat_vld = 1'b0;
    beat_x   = 8'd0;
    beat_y   = 7'd0;
    beat_col = 3'b000;
    case (state_nxt)
      INIT_DRAW: begin
        beat_vld = 1'b1;
        beat_x   = 8'(START_X);
        beat_y   = 7'(START_Y);
        beat_col = 3'b010;
      end
      ERASE_TAIL: begin
        beat_vld = 1'b1;
        beat_x   = tail_ent[14:7];
        beat_y   = tail_ent[6:0];
        beat_col = 3'b000;
      end
      DRAW_HEAD: begin
        beat_vld = 1'b1;
        beat_x   = nxt_x;
        beat_y   = nxt_y;
        beat_col = 3'b010;
      end
      default: ;
    endcase
  end

  // Plot beat register: reloads only when no beat is stalled, so fields hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plot_valid  <= 1'b0;
      plot_x      <= 8'd0;
      plot_y      <= 7'd0;
      plot_colour <= 3'b000;
    end else if (!(plot_valid && !plot_ready)) begin
      plot_valid  <= beat_vld;
      plot_x      <= beat_x;
      plot_y      <= beat_y;
      plot_colour <= beat_col;
    end
  end

  // Head, length, direction and scan bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      len      <= (ADDR_W + 1)'(1);
      cur_dir  <= 4'b1000;
      h_x      <= 8'(START_X);
      h_y      <= 7'(START_Y);
      nxt_x    <= 8'd0;
      nxt_y    <= 7'd0;
      scan_idx <= '0;
      grow_l   <= 1'b0;
    end else begin
      if (state != DEAD && dir_ok)
        cur_dir <= dir;
      case (state)
        IDLE: if (step) begin
          nxt_x    <= step_x;
          nxt_y    <= step_y;
          scan_idx <= '0;
          grow_l   <= growing;
        end
        CHECK: scan_idx <= scan_idx + 1'b1;
        COMMIT: begin
          head_ptr <= commit_addr;
          h_x      <= nxt_x;
          h_y      <= nxt_y;
          if (grow_l)
            len <= len + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Segment ring: entry 0 is seeded while drawing the start pixel, new heads land at head_ptr+1.
  always_ff @(posedge clk) begin
    if (state == INIT_DRAW)
      ring[0] <= {8'(START_X), 7'(START_Y)};
    else if (state == COMMIT)
      ring[commit_addr] <= {nxt_x, nxt_y};
  end

endmodule

// File: tb/tb_snake_body.sv
module tb_snake_body;

  logic        clk;
  logic        rst;
  logic        step;
  logic [3:0]  dir;
  logic [10:0] grow;
  logic [7:0]  h_x;
  logic [6:0]  h_y;
  logic        plot_valid;
  logic        plot_ready;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        busy;
  logic        dead;

  int total = 0;
  int bad   = 0;
  logic [17:0] bq[$];

  snake_body dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
    .h_x(h_x), .h_y(h_y),
    .plot_valid(plot_valid), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .busy(busy), .dead(dead)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Beat monitor: a beat pending at the falling edge with ready high transfers on the next rising edge.
  always @(negedge clk) begin
    if (plot_valid === 1'b1 && plot_ready === 1'b1)
      bq.push_back({plot_x, plot_y, plot_colour});
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic expect_beat(input string tag, input int x, input int y, input int c);
    int n = 0;
    logic [17:0] b;
    while (bq.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_present"}, int'(bq.size() > 0), 1);
    if (bq.size() > 0) begin
      b = bq.pop_front();
      chk({tag, "_x"}, int'(b[17:10]), x);
      chk({tag, "_y"}, int'(b[9:3]), y);
      chk({tag, "_col"}, int'(b[2:0]), c);
    end
  endtask

  task automatic do_step(input logic [3:0] d);
    dir = d;
    @(posedge clk); #1;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    wait_idle("step");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    dir = 4'b0000;
    step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_beat("init", 80, 60, 2);
    wait_idle("init");
    bq.delete();
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    step = 1'b0;
    dir = 4'b0000;
    grow = 11'd0;
    plot_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hx", int'(h_x), 80);
    chk("rst_hy", int'(h_y), 60);
    chk("rst_valid", int'(plot_valid), 0);
    chk("rst_px", int'(plot_x), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_dead", int'(dead), 0);
    rst = 1'b0;

    // Start pixel drawn exactly once
    expect_beat("init", 80, 60, 2);
    wait_idle("init");
    chk("init_busy", int'(busy), 0);
    chk("init_hx", int'(h_x), 80);
    chk("init_dead", int'(dead), 0);
    repeat (4) @(posedge clk);
    chk("init_only_one", bq.size(), 0);

    // Growth to length 6: draw-only beats
    grow = 11'd6;
    for (int i = 0; i < 5; i++) begin
      do_step(4'b1000);
      chk("grow_hx", int'(h_x), 81 + i);
      expect_beat("grow_draw", 81 + i, 60, 2);
      chk("grow_no_erase", bq.size(), 0);
    end
    do_step(4'b1000);
    expect_beat("full_erase", 80, 60, 0);
    expect_beat("full_draw", 86, 60, 2);
    chk("full_hx", int'(h_x), 86);

    // Wrap right edge
    guard = 0;
    while (h_x != 8'd159 && guard < 100) begin
      do_step(4'b1000);
      guard++;
    end
    chk("reach_159", int'(h_x), 159);
    bq.delete();
    do_step(4'b1000);
    chk("wrapx_hx", int'(h_x), 0);
    expect_beat("wrapx_erase", 154, 60, 0);
    expect_beat("wrapx_draw", 0, 60, 2);

    // Wrap top edge
    guard = 0;
    while (h_y != 7'd0 && guard < 100) begin
      do_step(4'b0001);
      guard++;
    end
    chk("reach_y0", int'(h_y), 0);
    bq.delete();
    do_step(4'b0001);
    chk("wrapy_hy", int'(h_y), 119);
    chk("wrapy_hx", int'(h_x), 0);
    expect_beat("wrapy_erase", 0, 5, 0);
    expect_beat("wrapy_draw", 0, 119, 2);

    // Ignored direction requests: reversal, multi-hot, none
    do_step(4'b1000);
    chk("turn_hx", int'(h_x), 1);
    do_step(4'b0100);
    chk("rev_hx", int'(h_x), 2);
    chk("rev_hy", int'(h_y), 119);
    do_step(4'b0011);
    chk("multi_hx", int'(h_x), 3);
    chk("multi_hy", int'(h_y), 119);
    do_step(4'b0000);
    chk("zero_hx", int'(h_x), 4);
    bq.delete();

    // Self-collision with the tail while still growing
    do_reset();
    grow = 11'd6;
    do_step(4'b1000);
    do_step(4'b0010);
    do_step(4'b0100);
    chk("col_pre_hx", int'(h_x), 80);
    chk("col_pre_hy", int'(h_y), 61);
    bq.delete();
    do_step(4'b0001);
    chk("col_dead", int'(dead), 1);
    chk("col_busy", int'(busy), 0);
    chk("col_hy", int'(h_y), 61);
    chk("col_valid", int'(plot_valid), 0);
    do_step(4'b1000);
    repeat (4) @(posedge clk);
    #1;
    chk("col_ignored_hx", int'(h_x), 80);
    chk("col_still_dead", int'(dead), 1);
    chk("col_no_beats", bq.size(), 0);

    // Same path at full length: tail cell vacated, no death
    do_reset();
    chk("rst2_dead", int'(dead), 0);
    grow = 11'd4;
    do_step(4'b1000);
    do_step(4'b0010);
    do_step(4'b0100);
    bq.delete();
    do_step(4'b0001);
    chk("vac_dead", int'(dead), 0);
    chk("vac_hy", int'(h_y), 60);
    expect_beat("vac_erase", 80, 60, 0);
    expect_beat("vac_draw", 80, 60, 2);

    // Backpressure during erase, extra steps dropped
    plot_ready = 1'b0;
    @(posedge clk); #1;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    guard = 0;
    while (!plot_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_valid", int'(plot_valid), 1);
    for (int i = 0; i < 10; i++) begin
      step = 1'b1;
      chk("bp_x", int'(plot_x), 81);
      chk("bp_y", int'(plot_y), 60);
      chk("bp_col", int'(plot_colour), 0);
      chk("bp_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    step = 1'b0;
    plot_ready = 1'b1;
    expect_beat("bp_erase", 81, 60, 0);
    expect_beat("bp_draw", 80, 59, 2);
    wait_idle("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hy", int'(h_y), 59);
    chk("bp_no_extra", bq.size(), 0);

    // Reset in the middle of a stalled beat
    plot_ready = 1'b0;
    @(posedge clk); #1;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    guard = 0;
    while (!plot_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("mid_valid", int'(plot_valid), 1);
    chk("mid_x", int'(plot_x), 81);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(plot_valid), 0);
    chk("mid_rst_px", int'(plot_x), 0);
    chk("mid_rst_hx", int'(h_x), 80);
    chk("mid_rst_hy", int'(h_y), 60);
    chk("mid_rst_busy", int'(busy), 1);
    plot_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_beat("mid_init", 80, 60, 2);
    wait_idle("mid");
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_extra", bq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
